// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID fields and forwarding sources in, the
// ID/EX pipeline register, stall request and stall counter out.
interface id_ex_stage_if #(
    parameter int unsigned PCW  = 30,
    parameter int unsigned CNTW = 16
);
    logic            id_valid;
    logic [5:0]      id_op;
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic [4:0]      id_rd;
    logic [4:0]      id_shamt;
    logic [5:0]      id_func;
    logic [PCW-1:0]  id_pc;
    logic [31:0]     id_ra;
    logic [31:0]     id_rb;
    logic            id_regwr;
    logic            id_regdst;
    logic            id_memrd;
    logic            id_memwr;
    logic            flush;
    logic [31:0]     ex_alure;
    logic            mem_regwr;
    logic [4:0]      mem_wreg;
    logic [31:0]     mem_data;

    logic            stall;
    logic            ex_valid;
    logic            ex_regwr;
    logic            ex_memrd;
    logic            ex_memwr;
    logic [4:0]      ex_wreg;
    logic [5:0]      ex_op;
    logic [5:0]      ex_func;
    logic [4:0]      ex_shamt;
    logic [PCW-1:0]  ex_pc;
    logic [15:0]     ex_imm;
    logic [31:0]     ex_a;
    logic [31:0]     ex_b;
    logic [CNTW-1:0] stall_cnt;

    modport slave (
        input  id_valid, id_op, id_rs, id_rt, id_rd, id_shamt, id_func, id_pc,
        input  id_ra, id_rb, id_regwr, id_regdst, id_memrd, id_memwr, flush,
        input  ex_alure, mem_regwr, mem_wreg, mem_data,
        output stall, ex_valid, ex_regwr, ex_memrd, ex_memwr, ex_wreg, ex_op,
        output ex_func, ex_shamt, ex_pc, ex_imm, ex_a, ex_b, stall_cnt
    );

    modport master (
        output id_valid, id_op, id_rs, id_rt, id_rd, id_shamt, id_func, id_pc,
        output id_ra, id_rb, id_regwr, id_regdst, id_memrd, id_memwr, flush,
        output ex_alure, mem_regwr, mem_wreg, mem_data,
        input  stall, ex_valid, ex_regwr, ex_memrd, ex_memwr, ex_wreg, ex_op,
        input  ex_func, ex_shamt, ex_pc, ex_imm, ex_a, ex_b, stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ID-stage operand forwarding, load-use stall
// detection and a saturating stall counter.
module id_ex_stage #(
    parameter int unsigned PCW  = 30,
    parameter int unsigned CNTW = 16
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    localparam logic [CNTW-1:0] CntOne = CNTW'(1);
    localparam logic [CNTW-1:0] CntMax = {CNTW{1'b1}};

    logic            ex_valid_q, ex_valid_d;
    logic            ex_regwr_q, ex_regwr_d;
    logic            ex_memrd_q, ex_memrd_d;
    logic            ex_memwr_q, ex_memwr_d;
    logic [4:0]      ex_wreg_q, ex_wreg_d;
    logic [5:0]      ex_op_q, ex_op_d;
    logic [5:0]      ex_func_q, ex_func_d;
    logic [4:0]      ex_shamt_q, ex_shamt_d;
    logic [PCW-1:0]  ex_pc_q, ex_pc_d;
    logic [15:0]     ex_imm_q, ex_imm_d;
    logic [31:0]     ex_a_q, ex_a_d;
    logic [31:0]     ex_b_q, ex_b_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    logic [4:0]  wreg;
    logic [31:0] fwd_a, fwd_b;
    logic        ex_fwd_ok;
    logic        stall;

    always_comb begin
        if (bus.id_op == 6'b000011 ||
            (bus.id_op == 6'b000000 && bus.id_func == 6'b001001 && bus.id_rd == 5'd31)) begin
            wreg = 5'd31;
        end else begin
            wreg = bus.id_regdst ? bus.id_rd : bus.id_rt;
        end

        // A load in EX has no result yet; only ALU results forward from EX.
        ex_fwd_ok = ex_valid_q && ex_regwr_q && !ex_memrd_q;

        if (bus.id_rs == 5'd0)                                 fwd_a = '0;
        else if (ex_fwd_ok && ex_wreg_q == bus.id_rs)          fwd_a = bus.ex_alure;
        else if (bus.mem_regwr && bus.mem_wreg == bus.id_rs)   fwd_a = bus.mem_data;
        else                                                   fwd_a = bus.id_ra;

        if (bus.id_rt == 5'd0)                                 fwd_b = '0;
        else if (ex_fwd_ok && ex_wreg_q == bus.id_rt)          fwd_b = bus.ex_alure;
        else if (bus.mem_regwr && bus.mem_wreg == bus.id_rt)   fwd_b = bus.mem_data;
        else                                                   fwd_b = bus.id_rb;

        // rt is compared for every opcode, even ones that never read it.
        stall = bus.id_valid && !bus.flush && ex_valid_q && ex_memrd_q && ex_regwr_q &&
                (ex_wreg_q != 5'd0) && (ex_wreg_q == bus.id_rs || ex_wreg_q == bus.id_rt);
    end

    always_comb begin
        ex_valid_d  = 1'b0;
        ex_regwr_d  = 1'b0;
        ex_memrd_d  = 1'b0;
        ex_memwr_d  = 1'b0;
        ex_wreg_d   = '0;
        ex_op_d     = '0;
        ex_func_d   = '0;
        ex_shamt_d  = '0;
        ex_pc_d     = '0;
        ex_imm_d    = '0;
        ex_a_d      = '0;
        ex_b_d      = '0;
        stall_cnt_d = stall_cnt_q;

        if (!bus.flush && !stall) begin
            ex_valid_d = bus.id_valid;
            ex_regwr_d = bus.id_valid && bus.id_regwr;
            ex_memrd_d = bus.id_valid && bus.id_memrd;
            ex_memwr_d = bus.id_valid && bus.id_memwr;
            ex_wreg_d  = wreg;
            ex_op_d    = bus.id_op;
            ex_func_d  = bus.id_func;
            ex_shamt_d = bus.id_shamt;
            ex_pc_d    = bus.id_pc;
            ex_imm_d   = {bus.id_rd, bus.id_shamt, bus.id_func};
            ex_a_d     = fwd_a;
            ex_b_d     = fwd_b;
        end

        if (stall && stall_cnt_q != CntMax) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid_q  <= 1'b0;
            ex_regwr_q  <= 1'b0;
            ex_memrd_q  <= 1'b0;
            ex_memwr_q  <= 1'b0;
            ex_wreg_q   <= '0;
            ex_op_q     <= '0;
            ex_func_q   <= '0;
            ex_shamt_q  <= '0;
            ex_pc_q     <= '0;
            ex_imm_q    <= '0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_regwr_q  <= ex_regwr_d;
            ex_memrd_q  <= ex_memrd_d;
            ex_memwr_q  <= ex_memwr_d;
            ex_wreg_q   <= ex_wreg_d;
            ex_op_q     <= ex_op_d;
            ex_func_q   <= ex_func_d;
            ex_shamt_q  <= ex_shamt_d;
            ex_pc_q     <= ex_pc_d;
            ex_imm_q    <= ex_imm_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_regwr  = ex_regwr_q;
    assign bus.ex_memrd  = ex_memrd_q;
    assign bus.ex_memwr  = ex_memwr_q;
    assign bus.ex_wreg   = ex_wreg_q;
    assign bus.ex_op     = ex_op_q;
    assign bus.ex_func   = ex_func_q;
    assign bus.ex_shamt  = ex_shamt_q;
    assign bus.ex_pc     = ex_pc_q;
    assign bus.ex_imm    = ex_imm_q;
    assign bus.ex_a      = ex_a_q;
    assign bus.ex_b      = ex_b_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expectations queued at drive time, popped
// and compared once the ID/EX register has captured them.
module tb_id_ex_stage;
    localparam int unsigned PCW   = 30;
    localparam int unsigned CNTW  = 16;
    localparam int unsigned SCNTW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if #(.PCW(PCW), .CNTW(CNTW))  bus ();
    id_ex_stage_if #(.PCW(PCW), .CNTW(SCNTW)) sbus ();

    id_ex_stage #(.PCW(PCW), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    id_ex_stage #(.PCW(PCW), .CNTW(SCNTW)) sat_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus)
    );

    typedef struct packed {
        logic            valid;
        logic            regwr;
        logic [4:0]      wreg;
        logic [31:0]     a;
        logic [31:0]     b;
        logic [PCW-1:0]  pc;
        logic [CNTW-1:0] cnt;
    } exp_t;

    exp_t            sb[$];
    exp_t            e;
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [CNTW-1:0] exp_cnt  = '0;

    localparam logic [5:0] OpR = 6'h00, OpJal = 6'h03, OpLw = 6'h23, FnAddu = 6'h21;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic [5:0] op, input logic [5:0] func, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd, input logic regdst,
                            input logic regwr, input logic memrd, input logic [31:0] ra,
                            input logic [31:0] rb, input logic [PCW-1:0] pc);
        bus.id_valid  = 1'b1;
        bus.id_op     = op;
        bus.id_func   = func;
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        bus.id_rd     = rd;
        bus.id_shamt  = 5'd0;
        bus.id_regdst = regdst;
        bus.id_regwr  = regwr;
        bus.id_memrd  = memrd;
        bus.id_memwr  = 1'b0;
        bus.id_ra     = ra;
        bus.id_rb     = rb;
        bus.id_pc     = pc;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_id(OpR, FnAddu, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'd5, 32'd7, 30'h40);
        repeat (2) tick();
        n_checks += 3;
        if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h want 0", bus.ex_valid); end
        if (bus.ex_a !== 32'd0) begin n_fail++; $display("FAIL reset_a got %0h want 0", bus.ex_a); end
        if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0h want 0", bus.stall_cnt); end
        reset = 1'b1;
        sb.push_back('{valid: 1'b1, regwr: 1'b1, wreg: 5'd3, a: 32'd5, b: 32'd7, pc: 30'h40, cnt: 16'd0});
        tick();
        e = sb.pop_front();
        n_checks += 4;
        if (bus.ex_valid !== e.valid) begin n_fail++; $display("FAIL rel_valid got %0h want %0h", bus.ex_valid, e.valid); end
        if (bus.ex_wreg !== e.wreg) begin n_fail++; $display("FAIL rel_wreg got %0d want %0d", bus.ex_wreg, e.wreg); end
        if (bus.ex_a !== e.a) begin n_fail++; $display("FAIL rel_a got %0h want %0h", bus.ex_a, e.a); end
        if (bus.ex_b !== e.b) begin n_fail++; $display("FAIL rel_b got %0h want %0h", bus.ex_b, e.b); end
    endtask

    task automatic test_ex_forward();
        logic [31:0] wa [3] = '{32'h1234, 32'h1234, 32'h99};
        logic [31:0] wb [3] = '{32'h77, 32'h1234, 32'hBEEF};
        logic [4:0]  rs [3] = '{5'd8, 5'd8, 5'd12};
        logic [4:0]  rt [3] = '{5'd9, 5'd8, 5'd8};
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                drive_id(OpR, FnAddu, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 30'h10);
                tick();
            end
            bus.ex_alure  = (i == 2) ? 32'h4444 : 32'h1234;
            bus.mem_regwr = (i != 0);
            bus.mem_wreg  = (i == 2) ? 5'd12 : 5'd8;
            bus.mem_data  = (i == 2) ? 32'h99 : 32'h55;
            drive_id(OpR, FnAddu, rs[i], rt[i], 5'd10, 1'b1, 1'b1, 1'b0, 32'hDEAD, wb[i] == 32'h1234 ? 32'hBEEF : wb[i], 30'h11);
            #1;
            n_checks++;
            if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL fwd%0d_stall got %0h want 0", i, bus.stall); end
            sb.push_back('{valid: 1'b1, regwr: 1'b1, wreg: 5'd10, a: wa[i], b: wb[i], pc: 30'h11, cnt: exp_cnt});
            tick();
            e = sb.pop_front();
            n_checks += 3;
            if (bus.ex_a !== e.a) begin n_fail++; $display("FAIL fwd%0d_a got %0h want %0h", i, bus.ex_a, e.a); end
            if (bus.ex_b !== e.b) begin n_fail++; $display("FAIL fwd%0d_b got %0h want %0h", i, bus.ex_b, e.b); end
            if (bus.ex_wreg !== e.wreg) begin n_fail++; $display("FAIL fwd%0d_wreg got %0d want %0d", i, bus.ex_wreg, e.wreg); end
        end
        bus.mem_regwr = 1'b0;
    endtask

    task automatic test_load_use();
        drive_id(OpLw, 6'h00, 5'd0, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 30'h20);
        tick();
        drive_id(OpR, FnAddu, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 32'hDEAD, 32'h66, 30'h21);
        #1;
        n_checks++;
        if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %0h want 1", bus.stall); end
        exp_cnt = exp_cnt + 16'd1;
        sb.push_back('{valid: 1'b0, regwr: 1'b0, wreg: 5'd0, a: 32'd0, b: 32'd0, pc: '0, cnt: exp_cnt});
        tick();
        e = sb.pop_front();
        n_checks += 3;
        if (bus.ex_valid !== e.valid) begin n_fail++; $display("FAIL lu_bubble got %0h want %0h", bus.ex_valid, e.valid); end
        if (bus.ex_regwr !== e.regwr) begin n_fail++; $display("FAIL lu_regwr got %0h want %0h", bus.ex_regwr, e.regwr); end
        if (bus.stall_cnt !== e.cnt) begin n_fail++; $display("FAIL lu_cnt got %0d want %0d", bus.stall_cnt, e.cnt); end
        bus.mem_regwr = 1'b1;
        bus.mem_wreg  = 5'd4;
        bus.mem_data  = 32'hABCD;
        #1;
        n_checks++;
        if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_release got %0h want 0", bus.stall); end
        sb.push_back('{valid: 1'b1, regwr: 1'b1, wreg: 5'd6, a: 32'hABCD, b: 32'h66, pc: 30'h21, cnt: exp_cnt});
        tick();
        e = sb.pop_front();
        n_checks += 3;
        if (bus.ex_a !== e.a) begin n_fail++; $display("FAIL lu_a got %0h want %0h", bus.ex_a, e.a); end
        if (bus.ex_valid !== e.valid) begin n_fail++; $display("FAIL lu_valid got %0h want %0h", bus.ex_valid, e.valid); end
        if (bus.ex_wreg !== e.wreg) begin n_fail++; $display("FAIL lu_wreg got %0d want %0d", bus.ex_wreg, e.wreg); end
        bus.mem_regwr = 1'b0;
    endtask

    task automatic test_zero_reg();
        drive_id(OpLw, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 30'h30);
        tick();
        drive_id(OpR, FnAddu, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 32'h111, 32'h222, 30'h31);
        #1;
        n_checks++;
        if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall got %0h want 0", bus.stall); end
        sb.push_back('{valid: 1'b1, regwr: 1'b1, wreg: 5'd7, a: 32'd0, b: 32'd0, pc: 30'h31, cnt: exp_cnt});
        tick();
        e = sb.pop_front();
        n_checks += 3;
        if (bus.ex_a !== e.a) begin n_fail++; $display("FAIL zero_a got %0h want %0h", bus.ex_a, e.a); end
        if (bus.ex_b !== e.b) begin n_fail++; $display("FAIL zero_b got %0h want %0h", bus.ex_b, e.b); end
        if (bus.ex_valid !== e.valid) begin n_fail++; $display("FAIL zero_valid got %0h want %0h", bus.ex_valid, e.valid); end
    endtask

    task automatic test_flush_hazard();
        drive_id(OpLw, 6'h00, 5'd0, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 30'h40);
        tick();
        drive_id(OpR, FnAddu, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 32'hDEAD, 32'h66, 30'h41);
        bus.flush = 1'b1;
        #1;
        n_checks++;
        if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %0h want 0", bus.stall); end
        sb.push_back('{valid: 1'b0, regwr: 1'b0, wreg: 5'd0, a: 32'd0, b: 32'd0, pc: '0, cnt: exp_cnt});
        tick();
        bus.flush = 1'b0;
        e = sb.pop_front();
        n_checks += 3;
        if (bus.ex_valid !== e.valid) begin n_fail++; $display("FAIL flush_valid got %0h want %0h", bus.ex_valid, e.valid); end
        if (bus.ex_regwr !== e.regwr) begin n_fail++; $display("FAIL flush_regwr got %0h want %0h", bus.ex_regwr, e.regwr); end
        if (bus.stall_cnt !== e.cnt) begin n_fail++; $display("FAIL flush_cnt got %0d want %0d", bus.stall_cnt, e.cnt); end
    endtask

    task automatic test_dest_decode();
        logic [5:0] op [4] = '{OpJal, OpR, OpR, OpR};
        logic [5:0] fn [4] = '{6'h00, 6'h09, 6'h09, FnAddu};
        logic [4:0] rd [4] = '{5'd0, 5'd31, 5'd12, 5'd12};
        logic [4:0] ew [4] = '{5'd31, 5'd31, 5'd5, 5'd5};
        for (int i = 0; i < 4; i++) begin
            drive_id(op[i], fn[i], 5'd0, 5'd5, rd[i], 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 30'h100);
            sb.push_back('{valid: 1'b1, regwr: 1'b1, wreg: ew[i], a: 32'd0, b: 32'd0, pc: 30'h100, cnt: exp_cnt});
            tick();
            e = sb.pop_front();
            n_checks += 2;
            if (bus.ex_wreg !== e.wreg) begin n_fail++; $display("FAIL dest%0d_wreg got %0d want %0d", i, bus.ex_wreg, e.wreg); end
            if (bus.ex_pc !== e.pc) begin n_fail++; $display("FAIL dest%0d_pc got %0h want %0h", i, bus.ex_pc, e.pc); end
        end
        drive_id(OpR, FnAddu, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'd9, 32'd9, 30'h55);
        bus.id_valid = 1'b0;
        bus.id_memwr = 1'b1;
        tick();
        n_checks += 3;
        if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL inv_valid got %0h want 0", bus.ex_valid); end
        if (bus.ex_regwr !== 1'b0) begin n_fail++; $display("FAIL inv_regwr got %0h want 0", bus.ex_regwr); end
        if (bus.ex_memwr !== 1'b0) begin n_fail++; $display("FAIL inv_memwr got %0h want 0", bus.ex_memwr); end
    endtask

    task automatic test_reset_mid_stall();
        drive_id(OpLw, 6'h00, 5'd0, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 30'h60);
        tick();
        drive_id(OpR, FnAddu, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 32'hDEAD, 32'h66, 30'h61);
        #1;
        n_checks++;
        if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL mid_stall got %0h want 1", bus.stall); end
        reset = 1'b0;
        tick();
        reset   = 1'b1;
        exp_cnt = '0;
        n_checks += 2;
        if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %0h want 0", bus.ex_valid); end
        if (bus.stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL mid_cnt got %0d want %0d", bus.stall_cnt, exp_cnt); end
        bus.id_valid = 1'b0;
    endtask

    task automatic test_saturation();
        logic [SCNTW-1:0] want;
        for (int k = 1; k <= (1 << SCNTW) + 3; k++) begin
            sbus.id_valid = 1'b1; sbus.id_op = OpLw; sbus.id_rs = 5'd0; sbus.id_rt = 5'd4;
            sbus.id_regdst = 1'b0; sbus.id_regwr = 1'b1; sbus.id_memrd = 1'b1;
            tick();
            sbus.id_op = OpR; sbus.id_func = FnAddu; sbus.id_rs = 5'd4; sbus.id_rt = 5'd5;
            sbus.id_rd = 5'd6; sbus.id_regdst = 1'b1; sbus.id_memrd = 1'b0;
            tick();
            want = (k < (1 << SCNTW) - 1) ? SCNTW'(k) : {SCNTW{1'b1}};
            n_checks++;
            if (sbus.stall_cnt !== want) begin
                n_fail++;
                $display("FAIL sat%0d_cnt got %0h want %0h", k, sbus.stall_cnt, want);
            end
        end
    endtask

    initial begin
        reset          = 1'b0;
        bus.id_valid   = 1'b0; bus.id_op = '0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
        bus.id_shamt   = '0; bus.id_func = '0; bus.id_pc = '0; bus.id_ra = '0; bus.id_rb = '0;
        bus.id_regwr   = 1'b0; bus.id_regdst = 1'b0; bus.id_memrd = 1'b0; bus.id_memwr = 1'b0;
        bus.flush      = 1'b0; bus.ex_alure = '0; bus.mem_regwr = 1'b0; bus.mem_wreg = '0;
        bus.mem_data   = '0;
        sbus.id_valid  = 1'b0; sbus.id_op = '0; sbus.id_rs = '0; sbus.id_rt = '0; sbus.id_rd = '0;
        sbus.id_shamt  = '0; sbus.id_func = '0; sbus.id_pc = '0; sbus.id_ra = '0; sbus.id_rb = '0;
        sbus.id_regwr  = 1'b0; sbus.id_regdst = 1'b0; sbus.id_memrd = 1'b0; sbus.id_memwr = 1'b0;
        sbus.flush     = 1'b0; sbus.ex_alure = '0; sbus.mem_regwr = 1'b0; sbus.mem_wreg = '0;
        sbus.mem_data  = '0;

        test_reset();
        test_ex_forward();
        test_load_use();
        test_zero_reg();
        test_flush_hazard();
        test_dest_decode();
        test_reset_mid_stall();
        test_saturation();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline boundary between decode (ID) and execute (EX) in the five-stage CPU.
- Consumes register-file read ports (ra/rb) and decoded instruction fields. Applies ID-stage operand forwarding from EX and MEM, and detects load-use hazards.
- On a load-use hazard, stalls IF/ID and inserts a bubble. Otherwise latches operands, destination register and control into the ID/EX register.
- Also keeps a saturating stall counter for performance debug.

Parameters:
- PCW, 30, PC width (PC[31:2] word address).
- CNTW, 16, stall counter width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- id_valid  input  1  ID holds a real instruction.
- id_op  input  6  opcode.
- id_rs, id_rt, id_rd, id_shamt  input  5 each  instruction fields.
- id_func  input  6  function field.
- id_pc  input  PCW  PC[31:2] of the ID instruction.
- id_ra, id_rb  input  32 each  register-file read data for rs/rt.
- id_regwr, id_regdst, id_memrd, id_memwr  input  1 each  decoded control.
- flush  input  1  branch/jump redirect; kill the ID instruction.
- ex_alure  input  32  combinational ALU result of the instruction currently in EX.
- mem_regwr  input  1  MEM-stage instruction writes a register.
- mem_wreg  input  5  MEM-stage destination register.
- mem_data  input  32  MEM-stage result (ALU result or load data).
- stall  output  1  hold PC and IF/ID (combinational).
- ex_valid, ex_regwr, ex_memrd, ex_memwr  output  1 each  registered control.
- ex_wreg  output  5  registered destination register.
- ex_op  output  6  registered opcode.
- ex_func  output  6  registered function field.
- ex_shamt  output  5  registered shift amount.
- ex_pc  output  PCW  registered PC.
- ex_imm  output  16  registered {id_rd, id_shamt, id_func}.
- ex_a, ex_b  output  32 each  registered forwarded operands.
- stall_cnt  output  CNTW  saturating count of stall cycles.

Behaviour:
- Reset (reset==0 at posedge): all ex_* outputs are 0 and stall_cnt is 0. Reset takes priority over flush and stall, and applies mid-stall too.
- Destination decode:
  - wreg = 31 if id_op==000011 (jal), or if id_op==0, id_func==001001 and id_rd==31 (jalr).
  - Otherwise wreg = id_rd if id_regdst, else id_rt.
- Operand forwarding for rs (rt identical, using id_rt/id_rb), in priority order:
  1. id_rs==0: operand is 0.
  2. ex_valid & ex_regwr & ~ex_memrd & ex_wreg==id_rs: operand is ex_alure.
  3. mem_regwr & mem_wreg==id_rs: operand is mem_data.
  4. Otherwise: operand is id_ra.
  - WB-to-ID needs no path, because the register file writes on negedge.
- Load-use hazard, combinational:
  - stall = id_valid & ~flush & ex_valid & ex_memrd & ex_regwr & ex_wreg!=0 & (ex_wreg==id_rs | ex_wreg==id_rt).
  - The rt comparison applies to every instruction; this is conservative by design.
- Register update each posedge, when not in reset:
  - flush=1: bubble (ex_valid, ex_regwr, ex_memrd, ex_memwr = 0; other ex_* fields don't care, held at 0).
  - stall=1: bubble (same as above).
  - Otherwise: capture all id_* fields and the forwarded operands; ex_valid = id_valid.
  - id_valid=0: control bits are captured as 0 regardless of id_regwr/id_memrd/id_memwr.
- Stall sequencing:
  - A stall lasts exactly one cycle: after the bubble, ex_valid=0, so the hazard clears.
  - The next cycle resolves through the MEM-forward path.
- stall_cnt: increments on each posedge where stall=1 and not in reset; saturates at all-ones.
- Simultaneous flush and hazard: flush wins, stall=0, bubble inserted, the counter does not increment.
- Latency: ID fields appear on ex_* one cycle after capture.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with id_valid=1 → ex_valid=0, ex_a=0, stall_cnt=0. Release: addu rd=3 with id_ra=5, id_rb=7 → next cycle ex_a=5, ex_b=7, ex_wreg=3.
2. EX forward: EX holds addu wreg=8 with ex_alure=0x1234; ID reads rs=8, id_ra=0xDEAD → ex_a=0x1234. Same case with additionally mem_wreg=8, mem_data=0x55 → ex_a still 0x1234 (EX priority).
3. Load-use: EX holds lw wreg=4; ID is addu rs=4 → stall=1 for one cycle, ex_valid=0 bubble, stall_cnt=1. Next cycle: mem_wreg=4, mem_data=0xABCD → ex_a=0xABCD, stall=0.
4. Zero register: EX holds lw wreg=0; ID reads rs=0 → stall=0, ex_a=0.
5. Flush during hazard: same setup as scenario 3 with flush=1 → stall=0, bubble inserted, stall_cnt unchanged.
6. jal at id_pc=0x100 → ex_wreg=31, ex_pc=0x100. Saturation: force 2^CNTW+3 stall cycles → stall_cnt holds 0xFFFF.
